// File: rtl/opseq_driver.sv
// opseq_driver: sequences a four-operand request onto start/din and returns the datapath result.
module opseq_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4*WIDTH-1:0] req_ops,
  output logic               start,
  output logic [WIDTH-1:0]   din,
  input  logic               dp_valid,
  input  logic [WIDTH-1:0]   dp_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               proto_err,
  output logic [CNT_W-1:0]   ops_done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, DRV_A, DRV_B, DRV_C, DRV_D, WAIT_VALID, RESP} state_t;
  state_t state, state_n;
  logic [4*WIDTH-1:0] ops;
  logic [TW-1:0] cnt;
  logic timeout;
  assign timeout = cnt == TW'(TIMEOUT - 1);
  always_comb begin
    state_n   = state;
    req_ready = state == IDLE && !rst;
    start     = state == DRV_A;
    rsp_valid = state == RESP;
    din = state == DRV_A ? ops[4*WIDTH-1 -: WIDTH] :
          state == DRV_B ? ops[3*WIDTH-1 -: WIDTH] :
          state == DRV_C ? ops[2*WIDTH-1 -: WIDTH] :
          state == DRV_D ? ops[WIDTH-1:0] : '0;
    case (state)
      IDLE:       state_n = req_valid ? DRV_A : IDLE;
      DRV_A:      state_n = DRV_B;
      DRV_B:      state_n = DRV_C;
      DRV_C:      state_n = DRV_D;
      DRV_D:      state_n = WAIT_VALID;
      WAIT_VALID: state_n = (dp_valid || timeout) ? RESP : WAIT_VALID;
      RESP:       state_n = rsp_ready ? IDLE : RESP;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      ops       <= '0;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      proto_err <= 1'b0;
      ops_done  <= '0;
    end else begin
      state <= state_n;
      if (req_valid && req_ready) ops <= req_ops;
      if (dp_valid && state != WAIT_VALID) proto_err <= 1'b1;
      // a real result takes priority over a timeout landing in the same cycle
      if (state == WAIT_VALID) begin
        cnt <= cnt + 1'b1;
        if (dp_valid) begin
          rsp_data <= dp_result;
          rsp_err  <= 1'b0;
        end else if (timeout) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) begin
        ops_done <= ops_done + 1'b1;
        cnt      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_opseq_driver.sv
// tb_opseq_driver: directed checks of opseq_driver against a behavioural controller/datapath.
module tb_opseq_driver;
  logic clock = 0, rst = 1, req_valid = 0, rsp_ready = 0, spur = 0, en = 1;
  logic [31:0] req_ops = 0;
  logic start, req_ready, rsp_valid, rsp_err, proto_err, dp_valid;
  logic [7:0] din, dp_result, rsp_data, acc;
  logic [15:0] ops_done;
  logic [2:0] ph;
  int total = 0, passed = 0, n;
  opseq_driver dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_ops(req_ops),
    .start(start), .din(din), .dp_valid(dp_valid), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .proto_err(proto_err), .ops_done(ops_done)
  );
  always #5 clock = ~clock;
  // controller + datapath: capture A on start, then +B, -C, -D, valid on the next cycle
  always @(posedge clock) begin
    if (rst) ph <= 0;
    else case (ph)
      0: if (start) begin acc <= din; ph <= 1; end
      1: begin acc <= acc + din; ph <= 2; end
      2: begin acc <= acc - din; ph <= 3; end
      3: begin acc <= acc - din; ph <= 4; end
      default: ph <= 0;
    endcase
  end
  assign dp_valid  = (en && ph == 4) || spur;
  assign dp_result = acc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask
  task automatic send(input logic [31:0] ops);
    int k = 0;
    req_valid = 1;
    req_ops = ops;
    while (!req_ready && k < 40) begin @(negedge clock); k++; end
    chk("accept", k < 40, 1);
    @(negedge clock);
    req_valid = 0;
  endtask
  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 40) begin @(negedge clock); cycles++; end
  endtask
  task automatic ack();
    rsp_ready = 1;
    @(negedge clock);
    rsp_ready = 0;
  endtask
  initial begin
    @(negedge clock);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_din", din, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_done", ops_done, 0);
    rst = 0;
    @(negedge clock);
    chk("idle_ready", req_ready, 1);
    send(32'h0A050302);
    chk("t1_start", start, 1);
    chk("t1_din_a", din, 10);
    @(negedge clock);
    chk("t2_start", start, 0);
    chk("t2_din_b", din, 5);
    @(negedge clock);
    chk("t3_din_c", din, 3);
    @(negedge clock);
    chk("t4_din_d", din, 2);
    wait_rsp(n);
    chk("lat_t6", n, 2);
    chk("op1_data", rsp_data, 10);
    chk("op1_err", rsp_err, 0);
    chk("resp_din", din, 0);
    chk("resp_ready", req_ready, 0);
    ack();
    chk("op1_done", ops_done, 1);
    send(32'h02010501);
    wait_rsp(n);
    chk("wrap_lat", n, 5);
    chk("wrap_data", rsp_data, 8'hFD);
    ack();
    chk("wrap_done", ops_done, 2);
    en = 0;
    send(32'h11223344);
    wait_rsp(n);
    chk("to_lat", n, 12);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 0);
    ack();
    chk("to_done", ops_done, 3);
    en = 1;
    send(32'h140A0301);
    wait_rsp(n);
    chk("hold_lat", n, 5);
    req_valid = 1;
    req_ops = 32'h01020304;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rspv", rsp_valid, 1);
      chk("hold_data", rsp_data, 26);
      chk("hold_ready", req_ready, 0);
      @(negedge clock);
    end
    ack();
    chk("hs_done", ops_done, 4);
    chk("hs_ready", req_ready, 1);
    @(negedge clock);
    req_valid = 0;
    chk("b2b_start", start, 1);
    chk("b2b_din", din, 1);
    wait_rsp(n);
    chk("b2b_lat", n, 5);
    chk("b2b_data", rsp_data, 8'hFC);
    ack();
    chk("b2b_done", ops_done, 5);
    chk("perr_pre", proto_err, 0);
    spur = 1;
    @(negedge clock);
    spur = 0;
    chk("perr_idle", proto_err, 1);
    send(32'h07060504);
    @(negedge clock);
    @(negedge clock);
    spur = 1;
    @(negedge clock);
    spur = 0;
    wait_rsp(n);
    chk("perr_lat", n, 2);
    chk("perr_data", rsp_data, 4);
    chk("perr_err", rsp_err, 0);
    ack();
    chk("perr_sticky", proto_err, 1);
    chk("perr_done", ops_done, 6);
    send(32'h55667788);
    @(negedge clock);
    chk("rb_din_b", din, 8'h66);
    rst = 1;
    @(negedge clock);
    rst = 0;
    chk("rb_start", start, 0);
    chk("rb_din", din, 0);
    chk("rb_rspv", rsp_valid, 0);
    chk("rb_perr", proto_err, 0);
    chk("rb_done", ops_done, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (rsp_valid || start) n++;
    end
    chk("rb_quiet", n, 0);
    chk("rb_ready", req_ready, 1);
    send(32'h09040201);
    wait_rsp(n);
    chk("rb_lat", n, 5);
    chk("rb_data", rsp_data, 10);
    ack();
    chk("rb_done2", ops_done, 1);
    chk("rb_perr2", proto_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/opseq_driver.md
Name: opseq_driver

Overview:
- Initiator-side sequencer for the start/cmd/valid accumulator controller-datapath pair.
- Accepts one four-operand request (A, B, C, D) on a ready/valid input.
- Pulses start and serialises the operands onto the shared din bus on the exact cycles the controller consumes them.
- Waits for the datapath's valid, then returns the result (nominally A+B-C-D mod 2^WIDTH) on a ready/valid output, with timeout and protocol-error detection.

Parameters:
WIDTH, 8, operand/result width in bits
TIMEOUT, 8, max WAIT_VALID cycles before declaring a timeout (>=1)
CNT_W, 16, width of completed-operation counter

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_ops  in  4*WIDTH  {A,B,C,D}; A in MSBs
start  out  1  start pulse to controller
din  out  WIDTH  operand bus to datapath
dp_valid  in  1  controller valid
dp_result  in  WIDTH  datapath result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  captured result
rsp_err  out  1  response is a timeout (data invalid)
proto_err  out  1  sticky: dp_valid seen outside WAIT_VALID
ops_done  out  CNT_W  count of responses delivered, wraps

Behaviour:
- States: IDLE, DRV_A, DRV_B, DRV_C, DRV_D, WAIT_VALID, RESP. start/din/req_ready/rsp_valid are Moore outputs of state.
- Reset (rst=1 at clock edge) forces IDLE, clears all outputs and registers: req_ready=0 in the reset cycle then 1 in IDLE, start=0, din=0, rsp_valid=0, rsp_data=0, rsp_err=0, proto_err=0, ops_done=0, timeout count=0. Reset overrides any in-flight op; no response emitted.
- IDLE: req_ready=1, din=0. On req_valid&&req_ready, latch A..D → DRV_A.
- DRV_A: start=1, din=A → DRV_B. This is the controller's capture cycle.
- DRV_B: din=B → DRV_C. DRV_C: din=C → DRV_D. DRV_D: din=D → WAIT_VALID.
- start is high for exactly one cycle per op. din=0 in every state other than DRV_x.
- WAIT_VALID:
  - counter increments each cycle.
  - If dp_valid=1: rsp_data<=dp_result, rsp_err<=0, → RESP.
  - Else if count reaches TIMEOUT-1 (TIMEOUT cycles elapsed): rsp_data<=0, rsp_err<=1, → RESP.
  - dp_valid wins if both occur in the same cycle.
  - Nominal: dp_valid arrives on the first WAIT_VALID cycle.
- RESP: rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready=1. On handshake: ops_done+1 (timeouts counted too), counter cleared → IDLE.
- req_ready=0 in all states but IDLE; no back-to-back overlap of ops.
- Latency: accept at cycle t → start at t+1 → dp_valid expected t+5 → rsp_valid from t+6.
- proto_err: set when dp_valid=1 in any state other than WAIT_VALID. Sticky until reset; does not alter the FSM.
- ops_done wraps from 2^CNT_W-1 to 0.
- No arithmetic is performed in this block; widths pass through unchanged.

Test Plan:
- Reset then single op A=10,B=5,C=3,D=2 with model controller+datapath → start high only at t+1; din=10,5,3,2 on t+1..t+4; rsp_valid at t+6, rsp_data=10, rsp_err=0, ops_done=1.
- Wrap arithmetic A=0x02,B=0x01,C=0x05,D=0x01 (WIDTH=8) → rsp_data=0xFD.
- Datapath stub never asserts dp_valid, TIMEOUT=8 → rsp_valid at 8 cycles after entering WAIT_VALID, rsp_err=1, rsp_data=0, ops_done increments.
- rsp_ready held low 5 cycles in RESP with req_valid=1 → rsp_data stable, req_ready=0 throughout; second request accepted the cycle after the response handshake.
- Spurious dp_valid pulse in IDLE, and a second one during DRV_C → proto_err=1 and stays 1; the op still completes with correct data.
- rst asserted in DRV_B → next cycle IDLE, start=0, din=0, no rsp_valid; a subsequent request completes normally.
